// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux_b scan controller: FSM encoding and the
// channel/select defaults common to mux_b and its driver.
package mux_scan_ctrl_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan controller, its requester and the mux_b under test.
// master = the controller side; slave = requester plus mux_b.
interface mux_scan_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);
  logic             start;
  logic [N_CH-1:0]  x_in;
  logic [N_CH-1:0]  mask;
  logic             g;
  logic [SEL_W-1:0] c;
  logic [N_CH-1:0]  x;
  logic             y;
  logic [N_CH-1:0]  d;
  logic [N_CH-1:0]  mismatch;
  logic             busy;
  logic             done;

  modport master (
    input  start, x_in, mask, y,
    output g, c, x, d, mismatch, busy, done
  );

  modport slave (
    output start, x_in, mask, y,
    input  g, c, x, d, mismatch, busy, done
  );
endinterface

// File: rtl/mux_ch_find.sv
// Combinational search for the lowest enabled channel at or above (incl=1)
// or strictly above (incl=0) a starting channel; never wraps.
module mux_ch_find
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] from,
  input  logic             incl,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  // Walk downward so the last hit written is the lowest qualifying channel.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(from)) || (incl && (i == int'(from))))) begin
        found = 1'b1;
        idx   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller for mux_b: walks C over the enabled channels with
// break-before-make strobing on G, captures Y into D and flags mismatches.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int SETTLE = 1
) (
  input logic           clk,
  input logic           rst,
  mux_scan_ctrl_if.master bus
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state, state_nxt;
  logic             accept;
  logic [N_CH-1:0]  x_q, mask_q, d_q, mis_q;
  logic [SEL_W-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  logic [N_CH-1:0]  find_mask;
  logic [SEL_W-1:0] find_from;
  logic             find_incl;
  logic             found;
  logic [SEL_W-1:0] find_idx;

  // One finder serves both the initial search (live MASK) and the step search.
  assign find_mask = (state == ST_IDLE) ? bus.mask : mask_q;
  assign find_from = (state == ST_IDLE) ? '0 : c_q;
  assign find_incl = (state == ST_IDLE);

  mux_ch_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_find (
    .mask  (find_mask),
    .from  (find_from),
    .incl  (find_incl),
    .found (found),
    .idx   (find_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = found ? ST_SETUP : ST_FIN;
        end
      end
      ST_SETUP:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt_q == '0) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = found ? ST_SETUP : ST_FIN;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // C is loaded on entry to SETUP, so it only ever moves while G is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      mask_q <= '0;
      d_q    <= '0;
      mis_q  <= '0;
      c_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q    <= bus.x_in;
        mask_q <= bus.mask;
        d_q    <= '0;
        mis_q  <= '0;
        busy_q <= 1'b1;
        if (found) c_q <= find_idx;
      end
      case (state)
        ST_SETUP:  cnt_q <= CNT_W'(SETTLE - 1);
        ST_SETTLE: if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        ST_SAMPLE: begin
          d_q[c_q]   <= bus.y;
          mis_q[c_q] <= (bus.y != x_q[c_q]);
          if (found) c_q <= find_idx;
        end
        ST_FIN:    busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.g        = !((state == ST_SETTLE) || (state == ST_SAMPLE));
  assign bus.c        = c_q;
  assign bus.x        = x_q;
  assign bus.d        = d_q;
  assign bus.mismatch = mis_q;
  assign bus.busy     = busy_q;
  assign bus.done     = (state == ST_FIN);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a behavioural mux_b (Y = G ? 0 : X[C]),
// with a stub mode that forces Y high; scoreboard checks each DONE.
module tb_mux_scan_ctrl;

  localparam int SETTLE = 1;
  localparam int PER_CH = 2 + SETTLE;

  typedef struct {
    logic [3:0]  d;
    logic [3:0]  mis;
    int          done_at;
    logic [15:0] seq;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_one = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  mux_scan_ctrl_if #(.N_CH(4), .SEL_W(2)) bus ();

  mux_scan_ctrl #(.N_CH(4), .SEL_W(2), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.y = stub_one ? 1'b1 : (bus.g ? 1'b0 : bus.x[bus.c]);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: records strobe order, guards C stability under G=0, scores DONE.
  logic [15:0] seq_act = '0;
  int          seq_n = 0;
  logic        prev_g = 1'b1;
  logic [1:0]  prev_c = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seq_act = '0;
      seq_n   = 0;
      prev_g  = 1'b1;
    end else begin
      if (!bus.g) begin
        if (prev_g) begin
          seq_act = {seq_act[11:0], 2'b00, bus.c};
          seq_n++;
        end else begin
          n_checks++;
          assert (bus.c == prev_c) else begin
            n_fail++;
            $display("FAIL c_stable_g_low: c=%0d, required %0d", bus.c, prev_c);
          end
        end
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending scan", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_at);
          check("d", {28'd0, bus.d}, {28'd0, e.d});
          check("mismatch", {28'd0, bus.mismatch}, {28'd0, e.mis});
          check("visit_seq", {16'd0, seq_act}, {16'd0, e.seq});
          check("visit_cnt", seq_n, e.n);
        end
        seq_act = '0;
        seq_n   = 0;
      end
      prev_g = bus.g;
      prev_c = bus.c;
    end
  end

  task automatic push_exp(input logic [3:0] d, mis, input logic [15:0] seq, input int n);
    exp_t e;
    e.d = d; e.mis = mis; e.seq = seq; e.n = n;
    e.done_at = cyc + n * PER_CH;
    sb.push_back(e);
  endtask

  task automatic run_scan(input logic [3:0] xi, mk, d, mis, input logic [15:0] seq, input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = xi;
    bus.mask  = mk;
    @(posedge clk);
    #1 push_exp(d, mis, seq, n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in  = ~xi;
    bus.mask  = ~mk;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check(name, (sb.size() == 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.mask  = '0;
    repeat (3) @(negedge clk);
    check("rst_g", bus.g, 1);
    check("rst_c", bus.c, 0);
    check("rst_x", bus.x, 0);
    check("rst_busy_done", {bus.busy, bus.done}, 0);
    rst = 1'b0;

    // Full mask, single high bit.
    run_scan(4'b0001, 4'b1111, 4'b0001, 4'b0000, 16'h0123, 4);
    @(negedge clk);
    check("busy_during_scan", bus.busy, 1);
    wait_drain("scan1_done");
    check("d_hold_after_done", bus.d, 4'b0001);
    check("busy_after_done", bus.busy, 0);

    // Sparse mask: only channels 0 and 2 are visited.
    run_scan(4'b1010, 4'b0101, 4'b0000, 4'b0000, 16'h0002, 2);
    wait_drain("scan2_done");

    // Empty mask: immediate DONE, no strobes.
    run_scan(4'b1111, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 0);
    wait_drain("scan3_done");

    // Stuck-high Y.
    stub_one = 1'b1;
    run_scan(4'b0110, 4'b1111, 4'b1111, 4'b1001, 16'h0123, 4);
    wait_drain("scan4_done");
    stub_one = 1'b0;

    // Reset during SETTLE of channel 2 abandons the scan.
    run_scan(4'b0101, 4'b1111, 4'b0000, 4'b0000, 16'h0000, 4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.g && bus.c == 2'd2) break;
    end
    check("reach_ch2_settle", {bus.g, bus.c}, {1'b0, 2'd2});
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_g", bus.g, 1);
    check("midrst_c", bus.c, 0);
    check("midrst_x", bus.x, 0);
    check("midrst_d_mis", {bus.d, bus.mismatch}, 0);
    check("midrst_busy_done", {bus.busy, bus.done}, 0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    run_scan(4'b1100, 4'b1010, 4'b1000, 4'b0000, 16'h0013, 2);
    wait_drain("scan5_done");

    // START held through BUSY and FIN is ignored; in the IDLE after FIN it
    // launches the next scan with the X_IN/MASK present then.
    begin
      int t0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x_in  = 4'b0101;
      bus.mask  = 4'b1001;
      @(posedge clk);
      #1 push_exp(4'b0001, 4'b0000, 16'h0003, 2);
      t0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.x_in  = 4'b0011;
      bus.mask  = 4'b0011;
      repeat (7) @(posedge clk);
      #1;
      check("relaunch_edge", cyc, t0 + 2 * PER_CH + 2);
      push_exp(4'b0011, 4'b0000, 16'h0001, 2);
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_drain("scan6_done");
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
